fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the write port of the dual-clock FIFO among several requesters in the write-clock domain. It grants one requester at a time for a bounded burst, drives `fifo_wr_en`/`fifo_data_in`, and back-pressures requesters from the FIFO `full` flag so that no write is ever attempted while the FIFO is full.

---
 rtl/fifo_wr_arbiter_pkg.sv | 18 +
 rtl/fifo_wr_arbiter_if.sv | 30 +++
 rtl/fifo_wr_arbiter_rr_picker.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 99 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_BURST_MAX  = 4;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side write bus of the arbiter.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    localparam int OW = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_data_in;
    logic                          busy;
    logic [OW-1:0]                 owner;

    modport master (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_data_in, busy, owner
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_data_in, busy, owner
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin search starting just above last_owner, wrapping modulo NUM_REQ.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int OW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [OW-1:0]      last_owner,
    output logic               any,
    output logic [OW-1:0]      winner
);

    always_comb begin
        int  idx;
        logic found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            // NUM_REQ need not be a power of two, so the wrap is explicit
            idx = int'(last_owner) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = OW'(idx);
            end
        end
    end

    assign any = |req_valid;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the dual-clock FIFO, bounded bursts, full back-pressure.
// Optional FIFO_ARB_HIPRI_EN: requester 0 wins every arbitration and does not move last_owner.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BURST_MAX  = DEF_BURST_MAX
) (
    input logic              wr_clk,
    input logic              rst_n,
    fifo_wr_arbiter_if.slave bus
);

    localparam int OW = idx_width(NUM_REQ);
    localparam int BW = idx_width(BURST_MAX + 1);

    arb_state_t          state;
    logic [OW-1:0]       owner_q;
    logic [OW-1:0]       last_owner;
    logic [BW-1:0]       beat_cnt;

    logic                pick_any;
    logic [OW-1:0]       pick_winner;
    logic [OW-1:0]       next_owner;
    logic                update_last;
    logic                accept;
    logic                burst_end;
    logic [NUM_REQ-1:0]  ready;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .OW      (OW)
    ) u_picker (
        .req_valid  (bus.req_valid),
        .last_owner (last_owner),
        .any        (pick_any),
        .winner     (pick_winner)
    );

`ifdef FIFO_ARB_HIPRI_EN
    always_comb begin
        next_owner = pick_winner;
        if (bus.req_valid[0]) next_owner = '0;
    end
    assign update_last = (owner_q != '0);
`else
    assign next_owner  = pick_winner;
    assign update_last = 1'b1;
`endif

    assign accept    = (state == XFER) && bus.req_valid[owner_q] && !bus.fifo_full;
    assign burst_end = bus.req_last[owner_q] || (beat_cnt == BW'(BURST_MAX - 1));

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner_q    <= '0;
            last_owner <= OW'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner_q  <= next_owner;
                        beat_cnt <= '0;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    // An abandoned burst ends the grant even while the FIFO is full
                    if (!bus.req_valid[owner_q]) begin
                        state <= IDLE;
                        if (update_last) last_owner <= owner_q;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + BW'(1);
                        if (burst_end) begin
                            state <= IDLE;
                            if (update_last) last_owner <= owner_q;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ready = '0;
        if ((state == XFER) && !bus.fifo_full) ready[owner_q] = 1'b1;
    end

    assign bus.req_ready    = ready;
    assign bus.fifo_wr_en   = accept;
    assign bus.fifo_data_in = bus.req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
    assign bus.busy         = (state == XFER);
    assign bus.owner        = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table for a single burst, hand sequences for the rest.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int BM = 4;

    logic wr_clk = 1'b0;
    logic rst_n  = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   wr_cnt = 0;
    int   words [NR];

    always #5 wr_clk = ~wr_clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .BURST_MAX  (BM)
    ) dut (
        .wr_clk (wr_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        full;
        logic [3:0]  e_ready;
        logic        e_wr;
        logic [7:0]  e_din;
        logic        e_busy;
        logic [1:0]  e_owner;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                         input logic f);
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
        bus.fifo_full = f;
    endtask

    // Let combinational outputs settle, then compare all outputs against expectations.
    task automatic expect_out(input string tag, input logic [3:0] rdy, input logic wr,
                              input logic [7:0] din, input logic bsy, input logic [1:0] own);
        #1;
        chk({tag, ".ready"}, 32'(bus.req_ready), 32'(rdy));
        chk({tag, ".wr_en"}, 32'(bus.fifo_wr_en), 32'(wr));
        if (wr) chk({tag, ".data"}, 32'(bus.fifo_data_in), 32'(din));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(bsy));
        chk({tag, ".owner"}, 32'(bus.owner), 32'(own));
        if (bus.fifo_wr_en) begin
            wr_cnt++;
            words[bus.owner]++;
        end
    endtask

    task automatic expect_idle(input string tag);
        #1;
        chk({tag, ".ready"}, 32'(bus.req_ready), 32'(0));
        chk({tag, ".wr_en"}, 32'(bus.fifo_wr_en), 32'(0));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(0));
    endtask

    task automatic step();
        @(posedge wr_clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(4'b0, 4'b0, 32'h0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        wr_cnt = 0;
        for (int i = 0; i < NR; i++) words[i] = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] k;
        logic [1:0] o;

        // Single burst from requester 2: 0x11, 0x22, 0x33 with last on 0x33
        vecs[0] = '{4'b0100, 4'b0000, 32'h0011_0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
        vecs[1] = '{4'b0100, 4'b0000, 32'h0011_0000, 1'b0, 4'b0100, 1'b1, 8'h11, 1'b1, 2'd2};
        vecs[2] = '{4'b0100, 4'b0000, 32'h0022_0000, 1'b0, 4'b0100, 1'b1, 8'h22, 1'b1, 2'd2};
        vecs[3] = '{4'b0100, 4'b0100, 32'h0033_0000, 1'b0, 4'b0100, 1'b1, 8'h33, 1'b1, 2'd2};
        vecs[4] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd2};
        vecs[5] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd2};

        drive(4'b0, 4'b0, 32'h0, 1'b0);
        #1;
        chk("reset.ready", 32'(bus.req_ready), 32'(0));
        chk("reset.wr_en", 32'(bus.fifo_wr_en), 32'(0));
        chk("reset.busy", 32'(bus.busy), 32'(0));
        chk("reset.owner", 32'(bus.owner), 32'(0));
        do_reset();

        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].valid, vecs[i].last, vecs[i].data, vecs[i].full);
            expect_out($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_wr,
                       vecs[i].e_din, vecs[i].e_busy, vecs[i].e_owner);
            step();
        end
        chk("single.words", 32'(wr_cnt), 32'(3));

        // All four requesters continuously valid: grants 0,1,2,3,0, four words each
        do_reset();
        drive(4'b1111, 4'b0000, 32'hA3A2_A1A0, 1'b0);
        for (int g = 0; g < 5; g++) begin
            o = 2'(g % NR);
            expect_idle($sformatf("rr.bubble%0d", g));
            step();
            for (int b = 0; b < BM; b++) begin
                expect_out($sformatf("rr.g%0d.b%0d", g, b), 4'(1 << o), 1'b1,
                           8'hA0 + 8'(o), 1'b1, o);
                step();
            end
        end
        expect_idle("rr.end");
        chk("rr.words0", 32'(words[0]), 32'(8));
        chk("rr.words1", 32'(words[1]), 32'(4));
        chk("rr.words2", 32'(words[2]), 32'(4));
        chk("rr.words3", 32'(words[3]), 32'(4));

        // Requester 1, full for 5 cycles after two words
        do_reset();
        k = 8'h50;
        drive(4'b0010, 4'b0000, {16'h0, k, 8'h0}, 1'b0);
        expect_idle("stall.arb");
        step();
        for (int c = 0; c < 9; c++) begin
            if (c >= 2 && c < 7) begin
                drive(4'b0010, 4'b0000, {16'h0, k, 8'h0}, 1'b1);
                expect_out($sformatf("stall.full%0d", c), 4'b0000, 1'b0, 8'h00, 1'b1, 2'd1);
            end else begin
                drive(4'b0010, 4'b0000, {16'h0, k, 8'h0}, 1'b0);
                expect_out($sformatf("stall.word%0d", c), 4'b0010, 1'b1, k, 1'b1, 2'd1);
                k = k + 8'h1;
            end
            step();
        end
        drive(4'b0000, 4'b0000, 32'h0, 1'b0);
        expect_idle("stall.done");
        chk("stall.words", 32'(wr_cnt), 32'(4));

        // Requester 3 abandons after one word; next grant wraps to 0
        do_reset();
        drive(4'b1000, 4'b0000, 32'h7700_0000, 1'b0);
        expect_idle("abandon.arb");
        step();
        expect_out("abandon.word", 4'b1000, 1'b1, 8'h77, 1'b1, 2'd3);
        step();
        drive(4'b0101, 4'b0000, 32'h0022_0011, 1'b0);
        expect_out("abandon.drop", 4'b1000, 1'b0, 8'h00, 1'b1, 2'd3);
        step();
        expect_idle("abandon.idle");
        step();
        expect_out("abandon.next", 4'b0001, 1'b1, 8'h11, 1'b1, 2'd0);

        // Asynchronous reset in the middle of a burst
        do_reset();
        drive(4'b0001, 4'b0000, 32'h0000_0042, 1'b0);
        step();
        expect_out("rstmid.word", 4'b0001, 1'b1, 8'h42, 1'b1, 2'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid.ready", 32'(bus.req_ready), 32'(0));
        chk("rstmid.wr_en", 32'(bus.fifo_wr_en), 32'(0));
        chk("rstmid.busy", 32'(bus.busy), 32'(0));
        step();
        rst_n = 1'b1;
        drive(4'b0110, 4'b0000, 32'h0000_2100, 1'b0);
        expect_idle("rstmid.arb");
        step();
        expect_out("rstmid.grant", 4'b0010, 1'b1, 8'h21, 1'b1, 2'd1);

        // After requester 1's burst, requesters 0 and 2 compete
        do_reset();
        drive(4'b0010, 4'b0010, 32'h0000_1100, 1'b0);
        expect_idle("cfg.arb1");
        step();
        expect_out("cfg.word1", 4'b0010, 1'b1, 8'h11, 1'b1, 2'd1);
        step();
        drive(4'b0101, 4'b0101, 32'h0022_0000 | 32'h0000_0000, 1'b0);
        expect_idle("cfg.arb2");
        step();
`ifdef FIFO_ARB_HIPRI_EN
        expect_out("cfg.hipri0", 4'b0001, 1'b1, 8'h00, 1'b1, 2'd0);
        step();
        drive(4'b1100, 4'b1100, 32'h3322_0000, 1'b0);
        expect_idle("cfg.arb3");
        step();
        expect_out("cfg.after0", 4'b0100, 1'b1, 8'h22, 1'b1, 2'd2);
`else
        expect_out("cfg.rr2", 4'b0100, 1'b1, 8'h22, 1'b1, 2'd2);
        step();
        drive(4'b1101, 4'b1101, 32'h3322_0000, 1'b0);
        expect_idle("cfg.arb3");
        step();
        expect_out("cfg.after2", 4'b1000, 1'b1, 8'h33, 1'b1, 2'd3);
`endif
        step();
        drive(4'b0000, 4'b0000, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
